// File: rtl/spmv_pkg.sv
// -----------------------------------------------------------------------------
// spmv_pkg: shared definitions for the CSR sparse matrix-vector engine.
//   - state_e     : engine FSM encoding
//   - RD_LAT      : read latency of every external RAM (cycles)
//   - DRAIN_CYC   : cycles needed to retire in-flight products after MAC
//   - sat_max/min : two's-complement limits for an accumulator of width w
// -----------------------------------------------------------------------------
package spmv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTR0  = 3'd1,
    S_PTR1  = 3'd2,
    S_ROW   = 3'd3,
    S_MAC   = 3'd4,
    S_DRAIN = 3'd5,
    S_EMIT  = 3'd6,
    S_FIN   = 3'd7
  } state_e;

  localparam int RD_LAT    = 1;
  localparam int DRAIN_CYC = 2 * RD_LAT;

  // Wide enough for any accumulator width the engine is built with;
  // callers truncate to their own width.
  localparam int SAT_W = 128;

  function automatic logic [SAT_W-1:0] sat_max(input int unsigned w);
    return (SAT_W'(1'b1) << (w - 1)) - SAT_W'(1'b1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int unsigned w);
    return SAT_W'(1'b1) << (w - 1);
  endfunction

endpackage

// File: rtl/spmv_if.sv
// -----------------------------------------------------------------------------
// spmv_if: RAM read ports and y result stream of the SpMV engine.
//   rp_*  : row-pointer RAM     val_* : value RAM
//   col_* : column-index RAM    x_*   : x vector RAM
//   y_*   : result stream (valid/ready)
// master = engine side, slave = RAMs + result consumer.
// -----------------------------------------------------------------------------
interface spmv_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 14,
  parameter int ACC_W  = 64
);
  logic        [IDX_W-1:0]  rp_addr;
  logic        [IDX_W-1:0]  rp_data;
  logic        [IDX_W-1:0]  val_addr;
  logic signed [DATA_W-1:0] val_data;
  logic        [IDX_W-1:0]  col_addr;
  logic        [DATA_W-1:0] col_data;
  logic        [IDX_W-1:0]  x_addr;
  logic signed [DATA_W-1:0] x_data;
  logic signed [ACC_W-1:0]  y_data;
  logic        [IDX_W-1:0]  y_row;
  logic                     y_valid;
  logic                     y_ready;
  logic                     y_zero;

  modport master (
    output rp_addr, val_addr, col_addr, x_addr, y_data, y_row, y_valid, y_zero,
    input  rp_data, val_data, col_data, x_data, y_ready
  );

  modport slave (
    input  rp_addr, val_addr, col_addr, x_addr, y_data, y_row, y_valid, y_zero,
    output rp_data, val_data, col_data, x_data, y_ready
  );
endinterface

// File: rtl/spmv_mac_sat.sv
// -----------------------------------------------------------------------------
// spmv_mac_sat: 2-stage signed multiply / accumulate pipe.
//   stage 1 registers val_in (with in_valid); stage 2 multiplies by x_in,
//   which arrives one cycle after val_in, and adds into the accumulator.
//   clr        : zero the accumulator (wins over an add)
//   acc        : accumulator (registered)
//   ovf_pulse  : combinational, high in the cycle an add overflows
// SATURATE=1 clamps on overflow, SATURATE=0 wraps.
// -----------------------------------------------------------------------------
module spmv_mac_sat
  import spmv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] val_in,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf_pulse
);
  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] val_q, val_d;
  logic                     v_q, v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic                     ovf_s;

  // Product, sign-extended sum and signed-overflow detection.
  always_comb begin
    val_d      = val_in;
    v_d        = in_valid;
    prod_s     = PROD_W'(val_q) * PROD_W'(x_in);
    prod_ext_s = ACC_W'(prod_s);
    sum_s      = acc_q + prod_ext_s;
    // Overflow only when both addends share a sign the result lacks.
    ovf_s      = (acc_q[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                 (sum_s[ACC_W-1] != acc_q[ACC_W-1]);
    acc_d      = acc_q;
    ovf_pulse  = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (v_q) begin
      ovf_pulse = ovf_s;
      if (ovf_s && SATURATE) begin
        acc_d = prod_ext_s[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
      end else begin
        acc_d = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      val_q <= val_d;
      v_q   <= v_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/spmv_csr_engine.sv
// -----------------------------------------------------------------------------
// spmv_csr_engine: y = A*x with A in CSR form (row pointers, values, column
// indices) and x held in external 1-cycle-latency RAMs.
//   clk, reset (async, active low)
//   start/num_rows : run request, sampled in IDLE
//   busy/done      : run in progress / one-cycle end-of-run pulse
//   ovf/err        : sticky overflow and malformed-CSR flags, cleared on start
//   bus (master)   : RAM address/data ports and y valid/ready stream
// -----------------------------------------------------------------------------
module spmv_csr_engine
  import spmv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 14,
  parameter int ACC_W    = 64,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] num_rows,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err,
  spmv_if.master           bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] num_rows_q, num_rows_d;
  logic [IDX_W-1:0] r_q, r_d;
  logic [IDX_W-1:0] p_start_q, p_start_d;
  logic [IDX_W-1:0] p_end_q, p_end_d;
  logic [IDX_W-1:0] rp_addr_q, rp_addr_d;
  logic [IDX_W-1:0] val_addr_q, val_addr_d;
  logic [1:0]       drain_q, drain_d;
  logic             mac_v_q, mac_v_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic             y_valid_q, y_valid_d, y_zero_q, y_zero_d;
  logic             acc_clr_s, mac_ovf_s;
  logic signed [ACC_W-1:0] acc_s;
  logic             col_hi_unused;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    r_d        = r_q;
    p_start_d  = p_start_q;
    p_end_d    = p_end_q;
    rp_addr_d  = rp_addr_q;
    val_addr_d = val_addr_q;
    drain_d    = drain_q;
    y_zero_d   = y_zero_q;
    err_d      = err_q;
    ovf_d      = ovf_q | mac_ovf_s;
    mac_v_d    = (state_q == S_MAC);
    acc_clr_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          ovf_d      = 1'b0;
          err_d      = 1'b0;
          r_d        = '0;
          rp_addr_d  = '0;
          if (num_rows == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_PTR0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PTR0: begin
        rp_addr_d = IDX_W'(1);
        state_d   = S_PTR1;
      end
      S_PTR1: begin
        p_start_d = bus.rp_data;
        state_d   = S_ROW;
      end
      S_ROW: begin
        p_end_d   = bus.rp_data;
        acc_clr_s = 1'b1;
        if (bus.rp_data < p_start_q) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (bus.rp_data == p_start_q) begin
          y_zero_d  = 1'b1;
          // Pre-address rp[r+2] so it is ready when the next row starts.
          rp_addr_d = r_q + IDX_W'(2);
          state_d   = S_EMIT;
        end else begin
          y_zero_d   = 1'b0;
          val_addr_d = p_start_q;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        val_addr_d = val_addr_q + IDX_W'(1);
        if (val_addr_q + IDX_W'(1) == p_end_q) begin
          drain_d = 2'd0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_MAC;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'(DRAIN_CYC - 1)) begin
          rp_addr_d = r_q + IDX_W'(2);
          state_d   = S_EMIT;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (bus.y_ready) begin
          r_d       = r_q + IDX_W'(1);
          p_start_d = p_end_q;
          if (r_q + IDX_W'(1) == num_rows_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ROW;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d    = (state_d == S_FIN);
    y_valid_d = (state_d == S_EMIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      r_q        <= '0;
      p_start_q  <= '0;
      p_end_q    <= '0;
      rp_addr_q  <= '0;
      val_addr_q <= '0;
      drain_q    <= 2'd0;
      mac_v_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      y_valid_q  <= 1'b0;
      y_zero_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      r_q        <= r_d;
      p_start_q  <= p_start_d;
      p_end_q    <= p_end_d;
      rp_addr_q  <= rp_addr_d;
      val_addr_q <= val_addr_d;
      drain_q    <= drain_d;
      mac_v_q    <= mac_v_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      y_valid_q  <= y_valid_d;
      y_zero_q   <= y_zero_d;
    end
  end

  spmv_mac_sat #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr_s),
    .in_valid (mac_v_q),
    .val_in   (bus.val_data),
    .x_in     (bus.x_data),
    .acc      (acc_s),
    .ovf_pulse(mac_ovf_s)
  );

  // Only the low IDX_W bits of a column word address x.
  assign col_hi_unused = ^bus.col_data[DATA_W-1:IDX_W];

  assign busy         = busy_q;
  assign done         = done_q;
  assign ovf          = ovf_q;
  assign err          = err_q;
  assign bus.rp_addr  = rp_addr_q;
  assign bus.val_addr = val_addr_q;
  assign bus.col_addr = val_addr_q;
  // Column data returned for an issued nonzero becomes the x address.
  assign bus.x_addr   = mac_v_q ? bus.col_data[IDX_W-1:0] : '0;
  assign bus.y_data   = acc_s;
  assign bus.y_row    = r_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_zero   = y_zero_q;

endmodule
